m6800_periph_port: RTL and testbench
====================================

// Module: m6800_periph_port
// PURPOSE
//  Target side of the 68000 6800-style synchronous bus cycle: a peripheral register port.
//  Decodes its address window with AS_n and asserts VPA_n. Waits for the host's VMA_n.
//  Runs one 8-bit register read or write locked to the E clock, then holds until AS_n rises.
//  Sits between the CPU-side 6800 cycle emulator (E/VMA_n/DTACK generation) and an internal register file.
// PARAMETERS
//  ADDR_W    8      width of ADDR compared for decode
//  BASE_ADDR 8'hA0  window base address
//  ADDR_MASK 8'hF0  bits of ADDR that must equal BASE_ADDR
//  REG_W     4      width of REG_ADDR (= ADDR[REG_W-1:0])
//  WAIT_MAX  40     C7M cycles allowed between VPA_n assertion and VMA_n low
// PORTS
//  C7M        in   1       system clock; all state updates on negedge C7M
//  RESET      in   1       asynchronous, active-high reset
//  ADDR       in   ADDR_W  CPU address
//  AS_n       in   1       CPU address strobe, active low
//  RW         in   1       1 = read, 0 = write
//  E          in   1       6800 E clock (10 C7M period: 6 low, 4 high)
//  VMA_n      in   1       valid memory address from the 6800 emulator, active low
//  DATA_IN    in   8       write data from CPU bus
//  DATA_OUT   out  8       read data to CPU bus
//  DATA_OE    out  1       drive enable for DATA_OUT
//  VPA_n      out  1       valid peripheral address, active low
//  REG_ADDR   out  REG_W   register index
//  REG_WDATA  out  8       write data to register file
//  REG_WR     out  1       one-cycle write strobe
//  REG_RD     out  1       one-cycle read strobe
//  REG_RDATA  in   8       register file read data, valid one cycle after REG_RD
//  TIMEOUT    out  1       sticky: VMA_n never arrived; cleared only by RESET
// BEHAVIOUR
//  Reset: VPA_n=1, DATA_OE=0, DATA_OUT=0, REG_WR=0, REG_RD=0, REG_ADDR=0, REG_WDATA=0, TIMEOUT=0, state IDLE.
//  Sync: AS_n, E, VMA_n each pass a 2-FF synchroniser (reset to 1,0,1). E_rise/E_fall = 1-cycle edge pulses on synced E.
//  Hit: !AS_s && ((ADDR & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)); ADDR and RW sampled in IDLE on the hit cycle.
//  FSM states and transitions:
//   IDLE:   on hit, VPA_n<=0, REG_ADDR<=ADDR[REG_W-1:0], latch RW, clear wait counter -> WAITV.
//   WAITV:  counter++ each cycle; VMA_s low -> WAITE.
//           Counter reaches WAIT_MAX -> TIMEOUT<=1, VPA_n<=1 -> HOLD.
//   WAITE:  on E_rise -> ACCESS. Read: REG_RD pulses on the E_rise cycle.
//   ACCESS: Read: cycle after REG_RD, DATA_OUT<=REG_RDATA and DATA_OE<=1; hold until AS_s high.
//           Write: REG_WDATA<=DATA_IN every cycle while E_s high. On E_fall, REG_WR pulses once with the last captured byte -> HOLD.
//           Read: on E_fall -> HOLD.
//   HOLD:   keep VPA_n and DATA_OE until AS_s high -> IDLE, VPA_n<=1, DATA_OE<=0.
//  Abort: AS_s high in any non-IDLE state -> IDLE next cycle, VPA_n<=1, DATA_OE<=0.
//   No strobe is issued after an abort. A strobe already issued stands.
//  At most one REG_WR or REG_RD per AS_n assertion. REG_WR and REG_RD are never high together.
//  Back-to-back: a new hit is accepted only after AS_s has been seen high (passing through IDLE).
//  VMA_n low while in IDLE or HOLD is ignored.
//  Latency: REG_RD fires 2-3 C7M after the E rise (sync delay); DATA_OE rises 1 cycle after REG_RD.
//  Wait counter width is $clog2(WAIT_MAX+1); it saturates and does not wrap.
// STRUCTURE
//  Package m6800_pkg: FSM state encoding (IDLE, WAITV, WAITE, ACCESS, HOLD); E_PERIOD=10, E_HIGH=4, E_LOW=6.
//  Sub-module m6800_sync: 2-FF synchroniser plus rise/fall pulse, instantiated for AS_n, E, VMA_n.
//  Top level holds the FSM, wait counter, and data/strobe registers.
// TESTING
//  1 Read ADDR=8'hA3, RW=1, VMA_n low 3 C7M after VPA_n -> REG_RD once with REG_ADDR=3;
//    REG_RDATA=8'h5C gives DATA_OUT=8'h5C, DATA_OE=1 until AS_n high.
//  2 Write ADDR=8'hAF, DATA_IN=8'h96 -> exactly one REG_WR after E falls, REG_ADDR=4'hF, REG_WDATA=8'h96;
//    VPA_n high 1 cycle after AS_s high.
//  3 ADDR=8'hB0 with AS_n low -> VPA_n stays 1, no strobes, DATA_OE=0.
//  4 VMA_n held high (CPU space cycle) for 60 C7M -> VPA_n released at WAIT_MAX=40, TIMEOUT=1, no strobes.
//  5 AS_n raised in WAITE before E rises -> IDLE, VPA_n=1, no REG_RD or REG_WR.
//  6 RESET pulsed mid-ACCESS read -> all outputs at reset values at once;
//    next hit after RESET falls completes normally.

Source files
------------

// File: rtl/m6800_pkg.sv
// Shared definitions for the 6800-style peripheral port: FSM encoding and E clock shape.
package m6800_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAITV,
    ST_WAITE,
    ST_ACCESS,
    ST_HOLD
  } state_e;

  localparam int E_PERIOD = 10;
  localparam int E_HIGH   = 4;
  localparam int E_LOW    = 6;
endpackage

// File: rtl/m6800_sync.sv
// Two-flop synchroniser for one asynchronous bus signal, with single-cycle
// rise/fall pulses derived from the synchronised level.
module m6800_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  // [0],[1] are the synchroniser; [2] is the previous synchronised level for edge detect
  logic [2:0] sh_q;

  // shift the input through; state changes on the falling C7M edge like the rest of the port
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) sh_q <= {3{RST_VAL}};
    else       sh_q <= {sh_q[1:0], d_i};
  end

  assign q_o    = sh_q[1];
  assign rise_o = sh_q[1] & ~sh_q[2];
  assign fall_o = ~sh_q[1] & sh_q[2];
endmodule

// File: rtl/m6800_periph_port.sv
// Target side of a 68000 6800-style synchronous bus cycle: decodes an address
// window, asserts VPA_n, waits for VMA_n, then performs one E-locked register
// read or write and holds until the CPU drops AS_n.
module m6800_periph_port
  import m6800_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'hA0,
  parameter logic [ADDR_W-1:0] ADDR_MASK = 8'hF0,
  parameter int                REG_W     = 4,
  parameter int                WAIT_MAX  = 40
) (
  input  logic              C7M,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              AS_n,
  input  logic              RW,
  input  logic              E,
  input  logic              VMA_n,
  input  logic [7:0]        DATA_IN,
  output logic [7:0]        DATA_OUT,
  output logic              DATA_OE,
  output logic              VPA_n,
  output logic [REG_W-1:0]  REG_ADDR,
  output logic [7:0]        REG_WDATA,
  output logic              REG_WR,
  output logic              REG_RD,
  input  logic [7:0]        REG_RDATA,
  output logic              TIMEOUT
);
  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  logic as_s, e_s, vma_s;
  logic e_rise, e_fall;
  logic as_rise_unused, as_fall_unused, vma_rise_unused, vma_fall_unused;

  m6800_sync #(.RST_VAL(1'b1)) u_sync_as (
    .clk_i(C7M), .rst_i(RESET), .d_i(AS_n),
    .q_o(as_s), .rise_o(as_rise_unused), .fall_o(as_fall_unused)
  );
  m6800_sync #(.RST_VAL(1'b0)) u_sync_e (
    .clk_i(C7M), .rst_i(RESET), .d_i(E),
    .q_o(e_s), .rise_o(e_rise), .fall_o(e_fall)
  );
  m6800_sync #(.RST_VAL(1'b1)) u_sync_vma (
    .clk_i(C7M), .rst_i(RESET), .d_i(VMA_n),
    .q_o(vma_s), .rise_o(vma_rise_unused), .fall_o(vma_fall_unused)
  );

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rw_q;
  logic               vpa_n_q, oe_q, wr_q, rd_q, tmo_q;
  logic [7:0]         dout_q, wdat_q;
  logic [REG_W-1:0]   radr_q;
  logic               hit;

  assign hit = !as_s && ((ADDR & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));

  // wait counter increments but saturates so a stuck host cannot wrap it
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != CNT_W'(WAIT_MAX)) cnt_d = cnt_q + CNT_W'(1);
  end

  // bus-cycle FSM with all outputs registered; strobes default low every cycle
  always_ff @(negedge C7M or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b1;
      vpa_n_q <= 1'b1;
      oe_q    <= 1'b0;
      dout_q  <= 8'h00;
      wdat_q  <= 8'h00;
      radr_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      // AS_n released: drop everything; any strobe not yet issued is simply never issued
      if (state_q != ST_IDLE && as_s) begin
        state_q <= ST_IDLE;
        vpa_n_q <= 1'b1;
        oe_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (hit) begin
              vpa_n_q <= 1'b0;
              radr_q  <= ADDR[REG_W-1:0];
              rw_q    <= RW;
              cnt_q   <= '0;
              state_q <= ST_WAITV;
            end
          end
          ST_WAITV: begin
            cnt_q <= cnt_d;
            if (!vma_s) begin
              state_q <= ST_WAITE;
            end else if (cnt_d == CNT_W'(WAIT_MAX)) begin
              tmo_q   <= 1'b1;
              vpa_n_q <= 1'b1;
              state_q <= ST_HOLD;
            end
          end
          ST_WAITE: begin
            if (e_rise) begin
              rd_q    <= rw_q;
              state_q <= ST_ACCESS;
            end
          end
          ST_ACCESS: begin
            if (rw_q) begin
              // register file answers in the cycle the read strobe is visible
              if (rd_q) begin
                dout_q <= REG_RDATA;
                oe_q   <= 1'b1;
              end
              if (e_fall) state_q <= ST_HOLD;
            end else begin
              if (e_s) wdat_q <= DATA_IN;
              if (e_fall) begin
                wr_q    <= 1'b1;
                state_q <= ST_HOLD;
              end
            end
          end
          ST_HOLD: ;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign DATA_OUT  = dout_q;
  assign DATA_OE   = oe_q;
  assign VPA_n     = vpa_n_q;
  assign REG_ADDR  = radr_q;
  assign REG_WDATA = wdat_q;
  assign REG_WR    = wr_q;
  assign REG_RD    = rd_q;
  assign TIMEOUT   = tmo_q;
endmodule

// File: tb/tb_m6800_periph_port.sv
// Bench for the 6800-style peripheral port: table vectors, randomized bus
// cycles against a transaction-level model, and hand-built corner sequences.
module tb_m6800_periph_port;
  logic       C7M = 1'b0;
  logic       RESET;
  logic [7:0] ADDR;
  logic       AS_n, RW, E, VMA_n;
  logic [7:0] DATA_IN, DATA_OUT, REG_WDATA, REG_RDATA;
  logic       DATA_OE, VPA_n, REG_WR, REG_RD, TIMEOUT;
  logic [3:0] REG_ADDR;

  m6800_periph_port dut (
    .C7M(C7M), .RESET(RESET), .ADDR(ADDR), .AS_n(AS_n), .RW(RW), .E(E),
    .VMA_n(VMA_n), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE),
    .VPA_n(VPA_n), .REG_ADDR(REG_ADDR), .REG_WDATA(REG_WDATA), .REG_WR(REG_WR),
    .REG_RD(REG_RD), .REG_RDATA(REG_RDATA), .TIMEOUT(TIMEOUT)
  );

  always #5 C7M = ~C7M;

  // free-running E: 6 C7M low, 4 high
  int e_cnt = 0;
  initial E = 1'b0;
  always @(posedge C7M) begin
    e_cnt = (e_cnt + 1) % 10;
    E = (e_cnt >= 6);
  end

  // strobe monitor, sampled on the edge opposite the DUT's
  int rd_n, wr_n, both_n, oe_n, vpa_low_n;
  logic [3:0] rd_a, wr_a;
  logic [7:0] wr_d;
  always @(posedge C7M) begin
    if (!RESET) begin
      if (REG_RD) begin rd_n++; rd_a = REG_ADDR; end
      if (REG_WR) begin wr_n++; wr_a = REG_ADDR; wr_d = REG_WDATA; end
      if (REG_RD && REG_WR) both_n++;
      if (DATA_OE) oe_n++;
      if (!VPA_n) vpa_low_n++;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge C7M);
    #1;
  endtask

  task automatic clr_mon();
    rd_n = 0; wr_n = 0; both_n = 0; oe_n = 0; vpa_low_n = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".vpa"},   VPA_n, 1);
    chk({tag, ".oe"},    DATA_OE, 0);
    chk({tag, ".dout"},  DATA_OUT, 0);
    chk({tag, ".wr"},    REG_WR, 0);
    chk({tag, ".rd"},    REG_RD, 0);
    chk({tag, ".radr"},  REG_ADDR, 0);
    chk({tag, ".wdat"},  REG_WDATA, 0);
    chk({tag, ".tmo"},   TIMEOUT, 0);
  endtask

  // one complete CPU bus cycle; expectations supplied by the caller
  task automatic run_xact(input string tag, input logic [7:0] addr, input bit rw,
                          input logic [7:0] wd, input logic [7:0] rd, input int vdly,
                          input bit e_hit, input bit e_rd, input bit e_wr,
                          input logic [7:0] e_dat, input logic [3:0] e_reg);
    int n;
    clr_mon();
    ADDR = addr; RW = rw; DATA_IN = wd; REG_RDATA = rd; VMA_n = 1'b1; AS_n = 1'b0;
    n = 0;
    while (VPA_n && n < 10) begin tick(); n++; end
    if (e_hit) begin
      chk({tag, ".vpa_lat"}, n, 3);
      if (!VPA_n) begin
        repeat (vdly) tick();
        VMA_n = 1'b0;
        n = 0;
        if (e_rd) begin
          while (!DATA_OE && n < 80) begin tick(); n++; end
          chk({tag, ".oe_up"}, DATA_OE, 1);
          chk({tag, ".dout"}, DATA_OUT, e_dat);
        end else begin
          while (wr_n == 0 && n < 80) begin tick(); n++; end
          chk({tag, ".wr_seen"}, (wr_n > 0), 1);
        end
        repeat (6) tick();
        chk({tag, ".vpa_hold"}, VPA_n, 0);
        chk({tag, ".oe_hold"}, DATA_OE, e_rd);
      end
    end else begin
      repeat (20) tick();
    end
    AS_n = 1'b1;
    tick(); tick();
    if (e_hit) chk({tag, ".vpa_pre_rel"}, VPA_n, 0);
    tick();
    chk({tag, ".vpa_rel"}, VPA_n, 1);
    chk({tag, ".oe_rel"}, DATA_OE, 0);
    VMA_n = 1'b1;
    repeat (3) tick();
    chk({tag, ".rd_cnt"}, rd_n, e_rd);
    chk({tag, ".wr_cnt"}, wr_n, e_wr);
    chk({tag, ".both"}, both_n, 0);
    if (e_rd) chk({tag, ".rd_adr"}, rd_a, e_reg);
    if (e_wr) begin
      chk({tag, ".wr_adr"}, wr_a, e_reg);
      chk({tag, ".wr_dat"}, wr_d, e_dat);
    end
    if (!e_hit) chk({tag, ".vpa_never"}, vpa_low_n, 0);
    if (!e_rd)  chk({tag, ".oe_never"}, oe_n, 0);
  endtask

  typedef struct {
    logic [7:0] addr;
    bit         rw;
    logic [7:0] wd;
    logic [7:0] rd;
    int         vdly;
    bit         hit;
    bit         e_rd;
    bit         e_wr;
    logic [7:0] dat;
    logic [3:0] reg_a;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n;
    logic [31:0] r;
    logic [7:0] a, wd, rd;
    bit rw, hit;

    tbl[0] = '{8'hA3, 1'b1, 8'h00, 8'h5C, 3,  1'b1, 1'b1, 1'b0, 8'h5C, 4'h3};
    tbl[1] = '{8'hAF, 1'b0, 8'h96, 8'h00, 3,  1'b1, 1'b0, 1'b1, 8'h96, 4'hF};
    tbl[2] = '{8'hB0, 1'b1, 8'h00, 8'h11, 3,  1'b0, 1'b0, 1'b0, 8'h00, 4'h0};
    tbl[3] = '{8'hA0, 1'b0, 8'h01, 8'h00, 0,  1'b1, 1'b0, 1'b1, 8'h01, 4'h0};
    tbl[4] = '{8'h9F, 1'b1, 8'h00, 8'h22, 2,  1'b0, 1'b0, 1'b0, 8'h00, 4'h0};
    tbl[5] = '{8'hAF, 1'b1, 8'h00, 8'hFF, 20, 1'b1, 1'b1, 1'b0, 8'hFF, 4'hF};
    tbl[6] = '{8'h20, 1'b0, 8'hE7, 8'h00, 1,  1'b0, 1'b0, 1'b0, 8'h00, 4'h0};

    RESET = 1'b1; AS_n = 1'b1; VMA_n = 1'b1; ADDR = 8'h00; RW = 1'b1;
    DATA_IN = 8'h00; REG_RDATA = 8'h00;
    clr_mon();
    tick(); tick();
    chk_reset("reset");
    RESET = 1'b0;
    repeat (4) tick();

    for (int i = 0; i < 7; i++)
      run_xact($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].rw, tbl[i].wd, tbl[i].rd,
               tbl[i].vdly, tbl[i].hit, tbl[i].e_rd, tbl[i].e_wr, tbl[i].dat, tbl[i].reg_a);

    // random cycles; model: window hit -> exactly one strobe of the requested kind
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      a = (r[1:0] == 2'b00) ? r[15:8] : {4'hA, r[19:16]};
      rw = r[20];
      r = $urandom;
      wd = r[7:0]; rd = r[15:8];
      hit = ((a & 8'hF0) == 8'hA0);
      run_xact($sformatf("rnd%0d", i), a, rw, wd, rd, int'($urandom_range(0, 30)),
               hit, hit && rw, hit && !rw, rw ? rd : wd, a[3:0]);
    end

    // AS_n dropped while waiting for E to rise: no strobe
    clr_mon();
    ADDR = 8'hA2; RW = 1'b1; REG_RDATA = 8'h77; AS_n = 1'b0;
    n = 0;
    while (VPA_n && n < 10) begin tick(); n++; end
    chk("abort.vpa_lat", n, 3);
    n = 0;
    while (!E && n < 20) begin tick(); n++; end
    while (E && n < 40) begin tick(); n++; end
    VMA_n = 1'b0;
    repeat (3) tick();
    AS_n = 1'b1;
    repeat (3) tick();
    chk("abort.vpa", VPA_n, 1);
    repeat (15) tick();
    chk("abort.rd", rd_n, 0);
    chk("abort.wr", wr_n, 0);
    chk("abort.oe", oe_n, 0);
    VMA_n = 1'b1;
    repeat (3) tick();

    // VMA_n never arrives: VPA_n released after WAIT_MAX cycles, sticky TIMEOUT
    clr_mon();
    ADDR = 8'hA9; RW = 1'b0; DATA_IN = 8'h5A; AS_n = 1'b0;
    n = 0;
    while (VPA_n && n < 10) begin tick(); n++; end
    chk("tmo.vpa_lat", n, 3);
    n = 0;
    while (!VPA_n && n < 80) begin tick(); n++; end
    chk("tmo.len", n, 40);
    chk("tmo.flag", TIMEOUT, 1);
    repeat (20) tick();
    chk("tmo.vpa_stays", VPA_n, 1);
    AS_n = 1'b1;
    repeat (4) tick();
    chk("tmo.rd", rd_n, 0);
    chk("tmo.wr", wr_n, 0);
    chk("tmo.sticky", TIMEOUT, 1);

    // reset in the middle of a read access
    clr_mon();
    ADDR = 8'hA5; RW = 1'b1; REG_RDATA = 8'h3C; AS_n = 1'b0; VMA_n = 1'b0;
    n = 0;
    while (!DATA_OE && n < 80) begin tick(); n++; end
    chk("rst.oe_up", DATA_OE, 1);
    RESET = 1'b1;
    #1;
    chk_reset("rst_mid");
    AS_n = 1'b1; VMA_n = 1'b1;
    tick(); tick();
    RESET = 1'b0;
    repeat (3) tick();
    run_xact("post_rst", 8'hA7, 1'b1, 8'h00, 8'hC3, 4, 1'b1, 1'b1, 1'b0, 8'hC3, 4'h7);
    chk("post_rst.tmo", TIMEOUT, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
